// File: rtl/bsg_manycore_pkg.sv
// Shared encodings and packet layouts for the manycore FIFO memory responder.
// Field order in the packed structs is MSB-first, so op and rsp_type sit at bit 0.
package bsg_manycore_pkg;

    localparam int x_cord_width_gp   = 7;
    localparam int y_cord_width_gp   = 7;
    localparam int addr_width_gp     = 28;
    localparam int op_width_gp       = 2;
    localparam int mask_width_gp     = 4;
    localparam int reg_id_width_gp   = 5;
    localparam int data_width_gp     = 32;
    localparam int rsp_type_width_gp = 2;

    typedef enum logic [1:0] {
        e_op_load     = 2'd0,
        e_op_store    = 2'd1,
        e_op_amoswap  = 2'd2,
        e_op_reserved = 2'd3
    } bsg_manycore_op_e;

    typedef enum logic [1:0] {
        e_rsp_load_data = 2'd0,
        e_rsp_store_ack = 2'd1,
        e_rsp_error     = 2'd2
    } bsg_manycore_rsp_type_e;

    typedef enum logic [1:0] {
        e_st_idle   = 2'd0,
        e_st_access = 2'd1,
        e_st_resp   = 2'd2
    } responder_state_e;

    typedef struct packed {
        logic [y_cord_width_gp-1:0] src_y;
        logic [x_cord_width_gp-1:0] src_x;
        logic [addr_width_gp-1:0]   addr;
        logic [data_width_gp-1:0]   data;
        logic [reg_id_width_gp-1:0] reg_id;
        logic [mask_width_gp-1:0]   mask;
        bsg_manycore_op_e           op;
    } bsg_manycore_req_s;

    typedef struct packed {
        logic [y_cord_width_gp-1:0] dst_y;
        logic [x_cord_width_gp-1:0] dst_x;
        logic [data_width_gp-1:0]   data;
        logic [reg_id_width_gp-1:0] reg_id;
        bsg_manycore_rsp_type_e     rsp_type;
    } bsg_manycore_rsp_s;

    // Amoswap replaces the whole word regardless of the byte mask it carries.
    function automatic logic [mask_width_gp-1:0] effective_write_mask(
        input bsg_manycore_op_e          op,
        input logic [mask_width_gp-1:0]  mask
    );
        return (op == e_op_amoswap) ? {mask_width_gp{1'b1}} : mask;
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables and read-first behaviour,
// so a same-cycle read+write returns the old word (needed for amoswap).
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int els_p        = 1024,
    parameter int data_width_p = 32,
    parameter int addr_width_p = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      v_i,
    input  logic                      w_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [data_width_p/8-1:0] write_mask_i,
    output logic [data_width_p-1:0]   data_o
);

    localparam int lanes_lp = data_width_p / 8;

    genvar gi;
    generate
        for (gi = 0; gi < lanes_lp; gi++) begin : g_lane
            // Each byte lane is its own RAM so byte writes map onto plain block RAMs.
            logic [7:0] r_mem [els_p];
            logic [7:0] r_q;

            always_ff @(posedge clk_i) begin
                if (v_i) begin
                    if (w_i && write_mask_i[gi]) begin
                        r_mem[addr_i] <= data_i[gi*8 +: 8];
                    end
                    r_q <= r_mem[addr_i];
                end
            end

            assign data_o[gi*8 +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/bsg_manycore_fifo_mem_responder.sv
// Serves load/store/amoswap requests from a host FIFO against a local word memory,
// one request at a time, with counters of completed and error responses.
module bsg_manycore_fifo_mem_responder
    import bsg_manycore_pkg::*;
#(
    parameter int fifo_width_p   = 128,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int mem_els_p      = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [fifo_width_p-1:0] req_i,
    input  logic                    req_v_i,
    output logic                    req_ready_o,
    output logic [fifo_width_p-1:0] rsp_o,
    output logic                    rsp_v_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             served_count_o,
    output logic [15:0]             err_count_o
);

    localparam int lg_els_lp   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int mask_lsb_lp = op_width_gp;
    localparam int reg_lsb_lp  = mask_lsb_lp + mask_width_gp;
    localparam int data_lsb_lp = reg_lsb_lp + reg_id_width_gp;
    localparam int addr_lsb_lp = data_lsb_lp + data_width_gp;
    localparam int x_lsb_lp    = addr_lsb_lp + addr_width_p;
    localparam int y_lsb_lp    = x_lsb_lp + x_cord_width_p;
    localparam int req_bits_lp = y_lsb_lp + y_cord_width_p;
    localparam int rsp_bits_lp = rsp_type_width_gp + reg_id_width_gp + data_width_gp
                               + x_cord_width_p + y_cord_width_p;
    localparam logic [addr_width_p:0] els_lp = (addr_width_p + 1)'(mem_els_p);

    responder_state_e              r_state;
    logic                          r_req_ready;
    bsg_manycore_op_e              r_op;
    logic [mask_width_gp-1:0]      r_mask;
    logic [reg_id_width_gp-1:0]    r_reg_id;
    logic [data_width_gp-1:0]      r_data;
    logic [addr_width_p-1:0]       r_addr;
    logic [x_cord_width_p-1:0]     r_src_x;
    logic [y_cord_width_p-1:0]     r_src_y;
    logic [fifo_width_p-1:0]       r_rsp;
    logic                          r_rsp_v;
    logic                          r_rsp_err;
    logic [31:0]                   r_served;
    logic [15:0]                   r_err_cnt;

    logic                          w_accept;
    logic                          w_is_err;
    logic                          w_mem_v;
    logic                          w_mem_w;
    logic [mask_width_gp-1:0]      w_mem_mask;
    logic [data_width_gp-1:0]      w_mem_rdata;
    bsg_manycore_rsp_type_e        w_rsp_type;
    logic [data_width_gp-1:0]      w_rsp_data;
    logic [rsp_bits_lp-1:0]        w_rsp_packed;

    generate
        if (fifo_width_p > req_bits_lp) begin : g_unused_req
            logic w_unused_upper;
            assign w_unused_upper = ^req_i[fifo_width_p-1:req_bits_lp];
        end
    endgenerate

    assign w_accept = req_v_i && r_req_ready && (r_state == e_st_idle);

    // Bad address or reserved op short-circuits the memory entirely.
    assign w_is_err   = ({1'b0, r_addr} >= els_lp) || (r_op == e_op_reserved);
    assign w_mem_v    = (r_state == e_st_access) && !w_is_err;
    assign w_mem_w    = w_mem_v && ((r_op == e_op_store) || (r_op == e_op_amoswap));
    assign w_mem_mask = effective_write_mask(r_op, r_mask);

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (data_width_p),
        .addr_width_p (lg_els_lp)
    ) u_mem (
        .clk_i        (clk_i),
        .v_i          (w_mem_v),
        .w_i          (w_mem_w),
        .addr_i       (lg_els_lp'(r_addr)),
        .data_i       (r_data),
        .write_mask_i (w_mem_mask),
        .data_o       (w_mem_rdata)
    );

    always_comb begin
        w_rsp_type = e_rsp_load_data;
        w_rsp_data = w_mem_rdata;
        if (w_is_err) begin
            w_rsp_type = e_rsp_error;
            w_rsp_data = data_width_gp'(r_addr);
        end else if (r_op == e_op_store) begin
            w_rsp_type = e_rsp_store_ack;
            w_rsp_data = '0;
        end
    end

    assign w_rsp_packed = {r_src_y, r_src_x, w_rsp_data, r_reg_id, w_rsp_type};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= e_st_idle;
            r_req_ready <= 1'b0;
            r_op        <= e_op_load;
            r_mask      <= '0;
            r_reg_id    <= '0;
            r_data      <= '0;
            r_addr      <= '0;
            r_src_x     <= '0;
            r_src_y     <= '0;
            r_rsp       <= '0;
            r_rsp_v     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_served    <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                e_st_idle: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_op        <= bsg_manycore_op_e'(req_i[op_width_gp-1:0]);
                        r_mask      <= req_i[mask_lsb_lp +: mask_width_gp];
                        r_reg_id    <= req_i[reg_lsb_lp +: reg_id_width_gp];
                        r_data      <= req_i[data_lsb_lp +: data_width_gp];
                        r_addr      <= req_i[addr_lsb_lp +: addr_width_p];
                        r_src_x     <= req_i[x_lsb_lp +: x_cord_width_p];
                        r_src_y     <= req_i[y_lsb_lp +: y_cord_width_p];
                        r_req_ready <= 1'b0;
                        r_state     <= e_st_access;
                    end
                end
                e_st_access: begin
                    r_state <= e_st_resp;
                end
                e_st_resp: begin
                    // First RESP cycle registers the packet from the RAM's output.
                    if (!r_rsp_v) begin
                        r_rsp     <= fifo_width_p'(w_rsp_packed);
                        r_rsp_v   <= 1'b1;
                        r_rsp_err <= w_is_err;
                    end else if (rsp_ready_i) begin
                        r_rsp_v     <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= e_st_idle;
                        r_served    <= r_served + 32'd1;
                        if (r_rsp_err && (r_err_cnt != 16'hFFFF)) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= e_st_idle;
                    r_req_ready <= 1'b0;
                    r_rsp_v     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o    = r_req_ready;
    assign rsp_o          = r_rsp;
    assign rsp_v_o        = r_rsp_v;
    assign served_count_o = r_served;
    assign err_count_o    = r_err_cnt;

endmodule
